// File: rtl/csi2_rx_pkt_ctrl.sv
// csi2_rx_pkt_ctrl: CSI-2 packet sequencer for the D-PHY slave receive path.
// Gates the PHY enable, parses headers, counts payload+CRC bytes and pulses eop_o.
// Ports: clk_i, rst_i (sync, active-high), en_i, rx_clk_present_i, data_i/valid_i,
//   clr_err_i in; phy_enable_o, eop_o, hdr_{valid,vc,dt,wc,ecc}_o,
//   payload_{o,valid_o,last_o}, pkt_cnt_o, err_timeout_o, err_clk_loss_o out.

module csi2_rx_pkt_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [5:0]  SHORT_DT_MAX   = 6'h0F
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        rx_clk_present_i,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  output logic        phy_enable_o,
  output logic        eop_o,
  output logic        hdr_valid_o,
  output logic [1:0]  hdr_vc_o,
  output logic [5:0]  hdr_dt_o,
  output logic [15:0] hdr_wc_o,
  output logic [7:0]  hdr_ecc_o,
  output logic [31:0] payload_o,
  output logic        payload_valid_o,
  output logic        payload_last_o,
  output logic [15:0] pkt_cnt_o,
  output logic        err_timeout_o,
  output logic        err_clk_loss_o,
  input  logic        clr_err_i
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOT,
    PAYLOAD,
    EOP
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [16:0]   rem_q;
  logic [TW-1:0] idle_q;
  logic          clk_loss;
  logic          is_short;
  logic          hdr_take;
  logic          word_take;
  logic          last_word;
  logic          timeout;

  assign is_short     = data_i[5:0] <= SHORT_DT_MAX;
  assign phy_enable_o = state_q != IDLE;
  assign eop_o        = state_q == EOP;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    clk_loss  = !rx_clk_present_i && (state_q != IDLE);
    hdr_take  = 1'b0;
    word_take = 1'b0;
    last_word = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_i && rx_clk_present_i) state_d = WAIT_SOT;
      end
      WAIT_SOT: begin
        if (valid_i) begin
          hdr_take = 1'b1;
          state_d  = is_short ? EOP : PAYLOAD;
        end else if (!en_i) begin
          state_d = IDLE;
        end
      end
      PAYLOAD: begin
        if (valid_i) begin
          word_take = 1'b1;
          if (rem_q <= 17'd4) begin
            last_word = 1'b1;
            state_d   = EOP;
          end
        end else if (idle_q == TO_LAST) begin
          timeout = 1'b1;
          state_d = EOP;
        end
      end
      EOP: begin
        state_d = (en_i && rx_clk_present_i) ? WAIT_SOT : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Losing the HS clock resets the lane datapath; drop whatever
    // this cycle would have done and go straight back to IDLE.
    if (clk_loss) begin
      state_d   = IDLE;
      hdr_take  = 1'b0;
      word_take = 1'b0;
      last_word = 1'b0;
      timeout   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hdr_valid_o     <= 1'b0;
      hdr_vc_o        <= '0;
      hdr_dt_o        <= '0;
      hdr_wc_o        <= '0;
      hdr_ecc_o       <= '0;
      payload_o       <= '0;
      payload_valid_o <= 1'b0;
      payload_last_o  <= 1'b0;
      pkt_cnt_o       <= '0;
      err_timeout_o   <= 1'b0;
      err_clk_loss_o  <= 1'b0;
      rem_q           <= '0;
      idle_q          <= '0;
    end else begin
      hdr_valid_o     <= hdr_take;
      payload_valid_o <= word_take;
      payload_last_o  <= last_word;
      if (hdr_take) begin
        hdr_vc_o  <= data_i[7:6];
        hdr_dt_o  <= data_i[5:0];
        hdr_wc_o  <= data_i[23:8];
        hdr_ecc_o <= data_i[31:24];
        // Payload bytes plus the 2-byte CRC; 17 bits so wc=FFFF fits.
        rem_q     <= {1'b0, data_i[23:8]} + 17'd2;
      end else if (word_take) begin
        rem_q <= rem_q - 17'd4;
      end
      if (word_take) payload_o <= data_i;
      if ((hdr_take && is_short) || last_word)
        pkt_cnt_o <= pkt_cnt_o + 16'd1;
      if (state_q != PAYLOAD || valid_i) idle_q <= '0;
      else                               idle_q <= idle_q + 1'b1;
      if (timeout)        err_timeout_o <= 1'b1;
      else if (clr_err_i) err_timeout_o <= 1'b0;
      if (clk_loss && state_q == PAYLOAD) err_clk_loss_o <= 1'b1;
      else if (clr_err_i)                 err_clk_loss_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_csi2_rx_pkt_ctrl.sv
// tb_csi2_rx_pkt_ctrl: self-checking bench for csi2_rx_pkt_ctrl.
// Vector table, directed corner sequences and a random packet stream vs. a packet model.

module tb_csi2_rx_pkt_ctrl;

  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic        rx_clk_present_i;
  logic [31:0] data_i;
  logic        valid_i;
  logic        clr_err_i;
  logic        phy_enable_o;
  logic        eop_o;
  logic        hdr_valid_o;
  logic [1:0]  hdr_vc_o;
  logic [5:0]  hdr_dt_o;
  logic [15:0] hdr_wc_o;
  logic [7:0]  hdr_ecc_o;
  logic [31:0] payload_o;
  logic        payload_valid_o;
  logic        payload_last_o;
  logic [15:0] pkt_cnt_o;
  logic        err_timeout_o;
  logic        err_clk_loss_o;

  csi2_rx_pkt_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .SHORT_DT_MAX  (6'h0F)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .en_i            (en_i),
    .rx_clk_present_i(rx_clk_present_i),
    .data_i          (data_i),
    .valid_i         (valid_i),
    .phy_enable_o    (phy_enable_o),
    .eop_o           (eop_o),
    .hdr_valid_o     (hdr_valid_o),
    .hdr_vc_o        (hdr_vc_o),
    .hdr_dt_o        (hdr_dt_o),
    .hdr_wc_o        (hdr_wc_o),
    .hdr_ecc_o       (hdr_ecc_o),
    .payload_o       (payload_o),
    .payload_valid_o (payload_valid_o),
    .payload_last_o  (payload_last_o),
    .pkt_cnt_o       (pkt_cnt_o),
    .err_timeout_o   (err_timeout_o),
    .err_clk_loss_o  (err_clk_loss_o),
    .clr_err_i       (clr_err_i)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic en, input logic ck, input logic v,
                       input logic [31:0] d);
    en_i             = en;
    rx_clk_present_i = ck;
    valid_i          = v;
    data_i           = d;
  endtask

  typedef struct packed {
    logic        en;
    logic        ck;
    logic        v;
    logic [31:0] d;
    logic        phy;
    logic        eop;
    logic        hv;
    logic        pv;
    logic        last;
    logic [31:0] pl;
    logic [15:0] cnt;
    logic [31:0] hdr;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [31:0] d,
                              input logic eop, input logic hv,
                              input logic pv, input logic last,
                              input logic [15:0] cnt);
    vec_t r;
    r.en   = 1'b1;
    r.ck   = 1'b1;
    r.v    = v;
    r.d    = d;
    r.phy  = 1'b1;
    r.eop  = eop;
    r.hv   = hv;
    r.pv   = pv;
    r.last = last;
    r.pl   = d;
    r.cnt  = cnt;
    r.hdr  = d;
    return r;
  endfunction

  // Random-phase packet model: expected headers and payload words.
  logic [31:0] exp_hdr[$];
  logic [31:0] got_hdr[$];
  logic [32:0] exp_pl[$];
  logic [32:0] got_pl[$];
  int          got_eop = 0;
  logic        mon_on  = 1'b0;

  always @(negedge clk_i) begin
    if (mon_on) begin
      if (hdr_valid_o)
        got_hdr.push_back({hdr_ecc_o, hdr_wc_o, hdr_vc_o, hdr_dt_o});
      if (payload_valid_o)
        got_pl.push_back({payload_last_o, payload_o});
      if (eop_o) got_eop++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt[15];
    int   words;
    logic done;
    int   npk;

    // Rows from reset (IDLE): long packet, short packet, wc=0,
    // header dropped in EOP cycle, wc=3.
    vt[0]  = mk(0, 32'h0, 0, 0, 0, 0, 16'd0);
    vt[1]  = mk(1, 32'h5C000A2A, 0, 1, 0, 0, 16'd0);
    vt[2]  = mk(1, 32'h11111111, 0, 0, 1, 0, 16'd0);
    vt[3]  = mk(1, 32'h22222222, 0, 0, 1, 0, 16'd0);
    vt[4]  = mk(1, 32'h33333333, 1, 0, 1, 1, 16'd1);
    vt[5]  = mk(0, 32'h0, 0, 0, 0, 0, 16'd1);
    vt[6]  = mk(1, 32'h1F000100, 1, 1, 0, 0, 16'd2);
    vt[7]  = mk(0, 32'h0, 0, 0, 0, 0, 16'd2);
    vt[8]  = mk(1, 32'h00000012, 0, 1, 0, 0, 16'd2);
    vt[9]  = mk(1, 32'hAAAA5555, 1, 0, 1, 1, 16'd3);
    vt[10] = mk(1, 32'h00000301, 0, 0, 0, 0, 16'd3);
    vt[11] = mk(1, 32'h00000320, 0, 1, 0, 0, 16'd3);
    vt[12] = mk(1, 32'h0000000D, 0, 0, 1, 0, 16'd3);
    vt[13] = mk(1, 32'h0000000E, 1, 0, 1, 1, 16'd4);
    vt[14] = mk(0, 32'h0, 0, 0, 0, 0, 16'd4);

    rst_i     = 1'b1;
    clr_err_i = 1'b0;
    drive(0, 0, 0, 32'h0);
    step();
    step();
    check("reset outputs",
          128'({phy_enable_o, eop_o, hdr_valid_o, hdr_vc_o, hdr_dt_o,
                hdr_wc_o, hdr_ecc_o, payload_o, payload_valid_o,
                payload_last_o, pkt_cnt_o, err_timeout_o, err_clk_loss_o}),
          128'd0);
    rst_i = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].en, vt[i].ck, vt[i].v, vt[i].d);
      step();
      check($sformatf("vec%0d ctrl", i),
            128'({phy_enable_o, eop_o, hdr_valid_o, payload_valid_o,
                  payload_last_o, pkt_cnt_o}),
            128'({vt[i].phy, vt[i].eop, vt[i].hv, vt[i].pv, vt[i].last,
                  vt[i].cnt}));
      if (vt[i].pv)
        check($sformatf("vec%0d payload", i), 128'(payload_o),
              128'(vt[i].pl));
      if (vt[i].hv)
        check($sformatf("vec%0d header", i),
              128'({hdr_ecc_o, hdr_wc_o, hdr_vc_o, hdr_dt_o}),
              128'(vt[i].hdr));
    end

    // wc = FFFF: 65537 bytes -> 16385 words, no 16-bit wrap.
    drive(1, 1, 1, 32'h00FFFF2B);
    step();
    check("wcmax header", 128'({hdr_valid_o, hdr_wc_o}), 128'({1'b1, 16'hFFFF}));
    words = 0;
    done  = 1'b0;
    for (int k = 0; k < 20000 && !done; k++) begin
      drive(1, 1, 1, k);
      step();
      if (payload_valid_o) words++;
      if (payload_last_o) begin
        done = 1'b1;
        check("wcmax eop with last", 128'(eop_o), 128'd1);
      end
    end
    check("wcmax finished", 128'(done), 128'd1);
    check("wcmax word count", 128'(words), 128'd16385);
    check("wcmax pkt_cnt", 128'(pkt_cnt_o), 128'd5);
    drive(1, 1, 0, 32'h0);
    step();

    // Timeout: wc=40, 2 words, then 16 idle cycles; clr in the set cycle loses.
    drive(1, 1, 1, 32'h0000282A);
    step();
    drive(1, 1, 1, 32'h1);
    step();
    drive(1, 1, 1, 32'h2);
    step();
    for (int k = 1; k <= TO; k++) begin
      clr_err_i = (k == TO);
      drive(1, 1, 0, 32'h0);
      step();
      if (k == TO - 1)
        check("timeout not early", 128'({eop_o, err_timeout_o}), 128'd0);
    end
    check("timeout abort",
          128'({eop_o, payload_last_o, err_timeout_o, pkt_cnt_o}),
          128'({1'b1, 1'b0, 1'b1, 16'd5}));
    clr_err_i = 1'b1;
    step();
    check("timeout cleared", 128'({err_timeout_o, phy_enable_o}), 128'({1'b0, 1'b1}));
    clr_err_i = 1'b0;

    // Clock loss in PAYLOAD.
    drive(1, 1, 1, 32'h0000082A);
    step();
    drive(1, 1, 1, 32'h5);
    step();
    drive(1, 0, 0, 32'h0);
    step();
    check("clk loss",
          128'({phy_enable_o, eop_o, err_clk_loss_o, payload_valid_o}),
          128'({1'b0, 1'b0, 1'b1, 1'b0}));
    step();
    check("clk loss idle", 128'({phy_enable_o, eop_o}), 128'd0);
    drive(1, 1, 0, 32'h0);
    step();
    check("clk restored", 128'({phy_enable_o, eop_o, pkt_cnt_o}),
          128'({1'b1, 1'b0, 16'd5}));
    clr_err_i = 1'b1;
    step();
    check("clk loss cleared", 128'(err_clk_loss_o), 128'd0);
    clr_err_i = 1'b0;

    // en_i drops mid packet: wc=8 -> 3 words, then IDLE.
    drive(1, 1, 1, 32'h0000082A);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 32'h100 + k);
      step();
      if (k == 0) check("en drop still on", 128'(phy_enable_o), 128'd1);
    end
    check("en drop end",
          128'({eop_o, payload_last_o, pkt_cnt_o}),
          128'({1'b1, 1'b1, 16'd6}));
    drive(0, 1, 0, 32'h0);
    step();
    check("en drop idle", 128'({phy_enable_o, eop_o}), 128'd0);

    // Reset mid packet.
    drive(1, 1, 0, 32'h0);
    step();
    drive(1, 1, 1, 32'h0000402A);
    step();
    drive(1, 1, 1, 32'hDEADBEEF);
    step();
    rst_i = 1'b1;
    step();
    check("reset mid packet",
          128'({phy_enable_o, eop_o, hdr_valid_o, hdr_vc_o, hdr_dt_o,
                hdr_wc_o, hdr_ecc_o, payload_o, payload_valid_o,
                payload_last_o, pkt_cnt_o, err_timeout_o, err_clk_loss_o}),
          128'd0);
    rst_i = 1'b0;

    // Random packet stream vs. packet-level model.
    npk    = 40;
    mon_on = 1'b1;
    drive(1, 1, 0, 32'h0);
    step();
    for (int p = 0; p < npk; p++) begin
      logic [5:0]  dt;
      logic [15:0] wc;
      logic [31:0] hdr;
      int          nw;
      dt  = 6'($urandom_range(0, 63));
      wc  = 16'($urandom_range(0, 40));
      hdr = {8'($urandom), wc, 2'($urandom), dt};
      exp_hdr.push_back(hdr);
      drive(1, 1, 1, hdr);
      step();
      if (dt > 6'h0F) begin
        nw = (int'(wc) + 2 + 3) / 4;
        for (int w = 0; w < nw; w++) begin
          logic [31:0] d;
          int gap;
          gap = $urandom_range(0, 3);
          for (int g = 0; g < gap; g++) begin
            drive(1, 1, 0, $urandom);
            step();
          end
          d = $urandom;
          exp_pl.push_back({(w == nw - 1), d});
          drive(1, 1, 1, d);
          step();
        end
      end
      drive(1, 1, 1'($urandom), $urandom);
      step();
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        drive(1, 1, 0, 32'h0);
        step();
      end
    end
    drive(1, 1, 0, 32'h0);
    step();
    step();
    mon_on = 1'b0;

    check("rnd header count", 128'(got_hdr.size()), 128'(exp_hdr.size()));
    check("rnd payload count", 128'(got_pl.size()), 128'(exp_pl.size()));
    for (int i = 0; i < exp_hdr.size() && i < got_hdr.size(); i++)
      check($sformatf("rnd hdr%0d", i), 128'(got_hdr[i]), 128'(exp_hdr[i]));
    for (int i = 0; i < exp_pl.size() && i < got_pl.size(); i++)
      check($sformatf("rnd pl%0d", i), 128'(got_pl[i]), 128'(exp_pl[i]));
    check("rnd eop count", 128'(got_eop), 128'(npk));
    check("rnd pkt_cnt", 128'(pkt_cnt_o), 128'(npk));
    check("rnd no errors", 128'({err_timeout_o, err_clk_loss_o}), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/csi2_rx_pkt_ctrl.md
Name: csi2_rx_pkt_ctrl

Overview:
Packet-level sequencer for the D-PHY slave receive datapath. It gates the PHY enable, parses each CSI-2 packet header from the 32-bit mapped word stream, and counts payload plus CRC bytes. At packet end it issues the one-cycle end-of-packet pulse that re-arms the word aligner. It sits between the D-PHY slave (byte clock domain) and downstream CSI-2 payload logic, and also handles timeout and clock-loss recovery.

Parameters:
TIMEOUT_CYCLES, 1024, consecutive cycles with valid_i low inside a packet before a forced end-of-packet (min 2).
SHORT_DT_MAX, 6'h0F, highest data type treated as a short packet.

Ports:
clk_i  input  1  byte clock; all logic in this single domain
rst_i  input  1  synchronous, active-high reset
en_i  input  1  software receive enable
rx_clk_present_i  input  1  HS clock-present indication from the PHY
data_i  input  32  mapped word; byte0 = data_i[7:0]
valid_i  input  1  data_i qualifier
phy_enable_o  output  1  enable to the PHY data lanes
eop_o  output  1  one-cycle end-of-packet pulse to the word aligner
hdr_valid_o  output  1  one-cycle pulse; header fields updated
hdr_vc_o  output  2  virtual channel, data_i[7:6] of header
hdr_dt_o  output  6  data type, data_i[5:0] of header
hdr_wc_o  output  16  word count, data_i[23:8] of header
hdr_ecc_o  output  8  ECC byte, data_i[31:24] of header (not checked)
payload_o  output  32  payload/CRC word, registered
payload_valid_o  output  1  payload_o qualifier
payload_last_o  output  1  final word of the long packet (contains CRC)
pkt_cnt_o  output  16  completed-packet counter, wraps 16'hFFFF to 0
err_timeout_o  output  1  sticky; set on timeout abort
err_clk_loss_o  output  1  sticky; set on clock loss inside a packet
clr_err_i  input  1  clears both sticky errors; set takes priority

Behaviour:
- Reset: state IDLE. All outputs are 0 after reset, including fields, counters and flags.
- States: IDLE, WAIT_SOT, PAYLOAD, EOP.
- IDLE:
  - phy_enable_o = 0.
  - Goes to WAIT_SOT when en_i & rx_clk_present_i.
- WAIT_SOT:
  - phy_enable_o = 1.
  - First valid_i word is the header. Header fields are registered and hdr_valid_o pulses the next cycle.
  - If dt <= SHORT_DT_MAX: go to EOP.
  - Otherwise: load rem = wc + 2 (17-bit, no overflow) and go to PAYLOAD.
  - If en_i is low with no header in the cycle, go to IDLE.
- PAYLOAD:
  - Each valid_i word is registered to payload_o with payload_valid_o = 1 (latency 1), and rem -= 4.
  - A word with rem <= 4 is last: payload_last_o = 1, go to EOP, pkt_cnt_o increments.
  - Examples: wc = 0 gives 1 word; wc = 3 gives 2 words.
- EOP:
  - eop_o = 1 for exactly one cycle; valid_i words are ignored.
  - Next state: WAIT_SOT if en_i & rx_clk_present_i, else IDLE.
- Latency:
  - eop_o is high one cycle after the last payload word was presented, coincident with payload_last_o.
  - For short packets, eop_o coincides with hdr_valid_o.
  - pkt_cnt_o also increments for short packets, in the header+1 cycle.
- en_i deasserted mid-packet: no effect until the packet ends; exit to IDLE from EOP.
- Timeout:
  - Idle counter clears on every valid_i and on entering PAYLOAD.
  - After TIMEOUT_CYCLES consecutive low cycles in PAYLOAD: go to EOP, set err_timeout_o, no pkt_cnt_o increment, no payload_last_o.
- Clock loss (rx_clk_present_i = 0) in any state except IDLE:
  - Next cycle: IDLE, phy_enable_o = 0, no eop_o (the datapath is reset by clock loss).
  - err_clk_loss_o is set if the state was PAYLOAD. Clock loss takes priority over the timeout and the last-word condition in the same cycle.
- Simultaneous set and clr_err_i: the flag ends set.

Test Plan:
1. Long packet: en_i = 1, clock present, header 32'h5C000A2A then 3 valid words → hdr_dt_o = 6'h2A, hdr_wc_o = 10, hdr_ecc_o = 8'h5C; payload_valid_o ×3 with last on the 3rd; eop_o in the same cycle as the 3rd; pkt_cnt_o = 1.
2. Short packet: header 32'h1F000100 (FS, wc = 1) → hdr_valid_o and eop_o both at header+1, no payload_valid_o; the next word starts a new header.
3. Boundaries: wc = 0 → 1 payload word, last; wc = 3 → 2 words; wc = 16'hFFFF → 16385 words without overflow; back-to-back headers with valid_i held high during EOP → the EOP-cycle word is dropped.
4. Timeout: TIMEOUT_CYCLES = 16, wc = 40, 2 words then valid_i low for 16 cycles → eop_o on the following cycle, err_timeout_o = 1, pkt_cnt_o unchanged; clr_err_i clears it.
5. Clock loss: rx_clk_present_i drops in PAYLOAD → IDLE next cycle, phy_enable_o = 0, err_clk_loss_o = 1, no eop_o; restore the clock → WAIT_SOT.
6. en_i drops mid long packet → packet completes normally, then IDLE with phy_enable_o = 0; assert rst_i mid-packet → all outputs 0 the next cycle.
